set_packer: RTL and testbench

- Upstream feeder for the ring buffer in the convolution accelerator datapath.
- Accepts a serial stream of DATA_WIDTH-bit elements over a valid/ready handshake and packs DATA_OF_SET consecutive elements into one set.
- Writes each completed set into the ring buffer with wen/din and obeys the buffer's full_flag backpressure.
- in_last closes a partial set early and zero-pads the unfilled lanes.

---
 rtl/set_packer_if.sv | 30 +++
 rtl/set_packer.sv | 90 +++++++++
 tb/tb_set_packer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/set_packer_if.sv
// Element-in / set-out bundle between a stream source, the set packer and the ring buffer.
// Carries no state. It only groups the wires, so it adds no latency.
// Backpressure uses in_ready toward the source and full_flag from the ring buffer.
interface set_packer_if #(
    parameter int DATA_WIDTH  = 4,
    parameter int DATA_OF_SET = 4,
    parameter int COUNT_WIDTH = 16
);
    logic                                        in_valid;
    logic                                        in_ready;
    logic [DATA_WIDTH-1:0]                       in_data;
    logic                                        in_last;
    logic                                        full_flag;
    logic                                        wen;
    logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0]      din;
    logic                                        busy;
    logic [COUNT_WIDTH-1:0]                      sets_written;

    // Source side. It also plays the ring buffer (drives full_flag, observes the write).
    modport master (
        output in_valid, in_data, in_last, full_flag,
        input  in_ready, wen, din, busy, sets_written
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_last, full_flag,
        output in_ready, wen, din, busy, sets_written
    );
endinterface

// File: rtl/set_packer.sv
// Packs DATA_OF_SET serial elements into one set and writes it to the ring buffer. in_last closes a set early and zero-pads it.
// A completed set appears on wen/din one cycle after its final element is accepted, provided full_flag is low.
// in_ready drops only when a completed set is waiting and the buffer is full. din is held stable while waiting.
module set_packer #(
    parameter int DATA_WIDTH  = 4,
    parameter int DATA_OF_SET = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    set_packer_if.slave  bus
);
    localparam int IDX_W = (DATA_OF_SET > 1) ? $clog2(DATA_OF_SET) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_OF_SET - 1);

    typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_t;

    logic [IDX_W-1:0]       idx_q, idx_d;
    set_t                   pack_q, pack_d;
    set_t                   pend_q, pend_d;
    set_t                   merged;
    logic                   pend_vld_q, pend_vld_d;
    logic [COUNT_WIDTH-1:0] sets_q, sets_d;
    logic                   accept;
    logic                   complete;
    logic                   wr;

    // A waiting set blocks new input only while the buffer is full. Otherwise the drain and the accept share the edge.
    assign bus.in_ready     = !pend_vld_q || !bus.full_flag;
    // rst gates the write so that a set discarded by reset never reaches the buffer.
    assign wr               = pend_vld_q && !bus.full_flag && !rst;
    assign bus.wen          = wr;
    assign bus.din          = pend_q;
    assign bus.busy         = (idx_q != '0) || pend_vld_q;
    assign bus.sets_written = sets_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign complete = accept && ((idx_q == LAST_IDX) || bus.in_last);

    // Build the completed set from the lanes already packed, the incoming element at lane idx, and zeros above it.
    always_comb begin
        merged = '0;
        for (int i = 0; i < DATA_OF_SET; i++) begin
            if (i < int'(idx_q)) begin
                merged[i] = pack_q[i];
            end else if (i == int'(idx_q)) begin
                merged[i] = bus.in_data;
            end
        end
    end

    // Next-state logic. A drain and a completion on the same edge reload pending without a bubble.
    always_comb begin
        idx_d      = idx_q;
        pack_d     = pack_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sets_d     = sets_q;
        if (wr) begin
            pend_vld_d = 1'b0;
            sets_d     = sets_q + COUNT_WIDTH'(1);
        end
        if (complete) begin
            pend_d     = merged;
            pend_vld_d = 1'b1;
            idx_d      = '0;
            pack_d     = '0;
        end else if (accept) begin
            pack_d[idx_q] = bus.in_data;
            idx_d         = idx_q + IDX_W'(1);
        end
    end

    // State registers. Reset discards any partial or pending set.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            pack_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            sets_q     <= '0;
        end else begin
            idx_q      <= idx_d;
            pack_q     <= pack_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sets_q     <= sets_d;
        end
    end
endmodule

// File: tb/tb_set_packer.sv
// Directed, table-driven bench for set_packer with DATA_WIDTH=4 and DATA_OF_SET=4.
// Each record is one clock cycle. Inputs are applied after the rising edge and outputs are compared on the falling edge.
// Expected din values are written lanes 3..0, most significant nibble first.
module tb_set_packer;
    logic clk;
    logic rst;

    set_packer_if #(.DATA_WIDTH(4), .DATA_OF_SET(4), .COUNT_WIDTH(16)) bus ();

    set_packer #(.DATA_WIDTH(4), .DATA_OF_SET(4), .COUNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [3:0]  dat;
        logic        last;
        logic        full;
        logic        rst;
        logic        exp_rdy;
        logic        exp_wen;
        logic [15:0] exp_din;
        logic        exp_busy;
        logic [15:0] exp_sw;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;

    task automatic add(input logic v, input logic [3:0] d, input logic l, input logic f, input logic r,
                       input logic er, input logic ew, input logic [15:0] edin, input logic eb,
                       input logic [15:0] esw);
        vec_t t;
        t.vld = v; t.dat = d; t.last = l; t.full = f; t.rst = r;
        t.exp_rdy = er; t.exp_wen = ew; t.exp_din = edin; t.exp_busy = eb; t.exp_sw = esw;
        vecs.push_back(t);
    endtask

    task automatic apply(input string tag, input int idx, input vec_t t);
        logic [15:0] din_now;
        rst           = t.rst;
        bus.in_valid  = t.vld;
        bus.in_data   = t.dat;
        bus.in_last   = t.last;
        bus.full_flag = t.full;
        @(negedge clk);
        din_now = bus.din;
        n_tests++;
        if (bus.in_ready !== t.exp_rdy || bus.wen !== t.exp_wen || din_now !== t.exp_din ||
            bus.busy !== t.exp_busy || bus.sets_written !== t.exp_sw) begin
            n_fail++;
            $display("FAIL %s[%0d]: got rdy=%b wen=%b din=%h busy=%b sw=%0d, want rdy=%b wen=%b din=%h busy=%b sw=%0d",
                     tag, idx, bus.in_ready, bus.wen, din_now, bus.busy, bus.sets_written,
                     t.exp_rdy, t.exp_wen, t.exp_din, t.exp_busy, t.exp_sw);
        end
        @(posedge clk);
        #1;
    endtask

    // Hand-written cycle: drive the inputs and check the outputs for one clock.
    task automatic cyc(input int idx, input logic v, input logic [3:0] d, input logic l, input logic f,
                       input logic er, input logic ew, input logic [15:0] edin, input logic eb,
                       input logic [15:0] esw);
        vec_t t;
        t.vld = v; t.dat = d; t.last = l; t.full = f; t.rst = 1'b0;
        t.exp_rdy = er; t.exp_wen = ew; t.exp_din = edin; t.exp_busy = eb; t.exp_sw = esw;
        apply("seq", idx, t);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.full_flag = 1'b0;

        //   v  d     l  f  r   rdy wen din      busy sw
        // Reset state.
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h0000, 0,  16'd0);
        // 1: full set 1,2,3,4.
        add(1, 4'h1, 0, 0, 0,  1,  0,  16'h0000, 0,  16'd0);
        add(1, 4'h2, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(1, 4'h3, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(1, 4'h4, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(0, 4'h0, 0, 0, 0,  1,  1,  16'h4321, 1,  16'd0);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h4321, 0,  16'd1);
        // 2: 5, then 6 with in_last.
        add(1, 4'h5, 0, 0, 0,  1,  0,  16'h4321, 0,  16'd1);
        add(1, 4'h6, 1, 0, 0,  1,  0,  16'h4321, 1,  16'd1);
        add(0, 4'h0, 0, 0, 0,  1,  1,  16'h0065, 1,  16'd1);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h0065, 0,  16'd2);
        // 3: 8,8,8,8 completes under full, held 5 cycles, then released.
        add(1, 4'h8, 0, 1, 0,  1,  0,  16'h0065, 0,  16'd2);
        add(1, 4'h8, 0, 1, 0,  1,  0,  16'h0065, 1,  16'd2);
        add(1, 4'h8, 0, 1, 0,  1,  0,  16'h0065, 1,  16'd2);
        add(1, 4'h8, 0, 1, 0,  1,  0,  16'h0065, 1,  16'd2);
        for (int k = 0; k < 5; k++)
            add(0, 4'h0, 0, 1, 0,  0,  0,  16'h8888, 1,  16'd2);
        add(0, 4'h0, 0, 0, 0,  1,  1,  16'h8888, 1,  16'd2);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h8888, 0,  16'd3);
        // 4: continuous 1..8, in_ready stays high, two writes four cycles apart.
        add(1, 4'h1, 0, 0, 0,  1,  0,  16'h8888, 0,  16'd3);
        add(1, 4'h2, 0, 0, 0,  1,  0,  16'h8888, 1,  16'd3);
        add(1, 4'h3, 0, 0, 0,  1,  0,  16'h8888, 1,  16'd3);
        add(1, 4'h4, 0, 0, 0,  1,  0,  16'h8888, 1,  16'd3);
        add(1, 4'h5, 0, 0, 0,  1,  1,  16'h4321, 1,  16'd3);
        add(1, 4'h6, 0, 0, 0,  1,  0,  16'h4321, 1,  16'd4);
        add(1, 4'h7, 0, 0, 0,  1,  0,  16'h4321, 1,  16'd4);
        add(1, 4'h8, 0, 0, 0,  1,  0,  16'h4321, 1,  16'd4);
        add(0, 4'h0, 0, 0, 0,  1,  1,  16'h8765, 1,  16'd4);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h8765, 0,  16'd5);
        // 5: fragment 1,2 dropped by reset, then 9,9,9,9.
        add(1, 4'h1, 0, 0, 0,  1,  0,  16'h8765, 0,  16'd5);
        add(1, 4'h2, 0, 0, 0,  1,  0,  16'h8765, 1,  16'd5);
        add(0, 4'h0, 0, 0, 1,  1,  0,  16'h8765, 1,  16'd5);
        add(1, 4'h9, 0, 0, 0,  1,  0,  16'h0000, 0,  16'd0);
        add(1, 4'h9, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(1, 4'h9, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(1, 4'h9, 0, 0, 0,  1,  0,  16'h0000, 1,  16'd0);
        add(0, 4'h0, 0, 0, 0,  1,  1,  16'h9999, 1,  16'd0);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h9999, 0,  16'd1);
        // A pending set is discarded by reset. No write occurs even though full drops during reset.
        add(1, 4'h3, 0, 1, 0,  1,  0,  16'h9999, 0,  16'd1);
        add(1, 4'h3, 0, 1, 0,  1,  0,  16'h9999, 1,  16'd1);
        add(1, 4'h3, 0, 1, 0,  1,  0,  16'h9999, 1,  16'd1);
        add(1, 4'h3, 0, 1, 0,  1,  0,  16'h9999, 1,  16'd1);
        add(0, 4'h0, 0, 0, 1,  1,  0,  16'h3333, 1,  16'd1);
        add(0, 4'h0, 0, 0, 0,  1,  0,  16'h0000, 0,  16'd0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) apply("vec", i, vecs[i]);

        // 6: set 1..4 pending under full while element 5 is stalled. Releasing full drains the pending set and accepts 5 on the same edge.
        cyc(0,  1, 4'h1, 0, 1,  1, 0, 16'h0000, 0, 16'd0);
        cyc(1,  1, 4'h2, 0, 1,  1, 0, 16'h0000, 1, 16'd0);
        cyc(2,  1, 4'h3, 0, 1,  1, 0, 16'h0000, 1, 16'd0);
        cyc(3,  1, 4'h4, 0, 1,  1, 0, 16'h0000, 1, 16'd0);
        cyc(4,  1, 4'h5, 0, 1,  0, 0, 16'h4321, 1, 16'd0);
        cyc(5,  1, 4'h5, 0, 1,  0, 0, 16'h4321, 1, 16'd0);
        cyc(6,  1, 4'h5, 0, 1,  0, 0, 16'h4321, 1, 16'd0);
        cyc(7,  1, 4'h5, 0, 0,  1, 1, 16'h4321, 1, 16'd0);
        cyc(8,  1, 4'h6, 0, 0,  1, 0, 16'h4321, 1, 16'd1);
        cyc(9,  1, 4'h7, 0, 0,  1, 0, 16'h4321, 1, 16'd1);
        cyc(10, 1, 4'h8, 0, 0,  1, 0, 16'h4321, 1, 16'd1);
        // A one-element set (in_last) completes on the edge that drains 8765. pending reloads with no bubble.
        cyc(11, 1, 4'hA, 1, 1,  0, 0, 16'h8765, 1, 16'd1);
        cyc(12, 1, 4'hA, 1, 0,  1, 1, 16'h8765, 1, 16'd1);
        cyc(13, 0, 4'h0, 0, 0,  1, 1, 16'h000A, 1, 16'd2);
        cyc(14, 0, 4'h0, 0, 0,  1, 0, 16'h000A, 0, 16'd3);
        // in_last on the final lane gives one normal write and no extra padding set.
        cyc(15, 1, 4'h1, 0, 0,  1, 0, 16'h000A, 0, 16'd3);
        cyc(16, 1, 4'h2, 0, 0,  1, 0, 16'h000A, 1, 16'd3);
        cyc(17, 1, 4'h3, 0, 0,  1, 0, 16'h000A, 1, 16'd3);
        cyc(18, 1, 4'h4, 1, 0,  1, 0, 16'h000A, 1, 16'd3);
        cyc(19, 0, 4'h0, 0, 0,  1, 1, 16'h4321, 1, 16'd3);
        cyc(20, 0, 4'h0, 0, 0,  1, 0, 16'h4321, 0, 16'd4);
        cyc(21, 0, 4'h0, 0, 0,  1, 0, 16'h4321, 0, 16'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
